// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-port memory between the DMA/loader,
// the instruction fetcher and the execute path. A registered owner FSM
// gives DMA fixed priority at arbitration points and alternates between
// fetch and exec. One beat per cycle goes to the owner; read data comes
// back from mem one cycle later, flagged by a per-port rvalid.
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_dma,
    input  logic                  req_fetch,
    input  logic                  req_exec,
    input  logic                  we_dma,
    input  logic                  we_fetch,
    input  logic                  we_exec,
    input  logic [ADDR_WIDTH-1:0] addr_dma,
    input  logic [ADDR_WIDTH-1:0] addr_fetch,
    input  logic [ADDR_WIDTH-1:0] addr_exec,
    input  logic [DATA_WIDTH-1:0] din_dma,
    input  logic [DATA_WIDTH-1:0] din_fetch,
    input  logic [DATA_WIDTH-1:0] din_exec,
    output logic                  gnt_dma,
    output logic                  gnt_fetch,
    output logic                  gnt_exec,
    output logic                  rvalid_dma,
    output logic                  rvalid_fetch,
    output logic                  rvalid_exec,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            owner,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    // Owner encoding doubles as the owner output value.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DMA   = 2'd1;
    localparam logic [1:0] ST_FETCH = 2'd2;
    localparam logic [1:0] ST_EXEC  = 2'd3;

    localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

    logic [1:0]            state_q, state_d;
    logic [7:0]            cnt_q, cnt_d, cnt_inc;
    logic                  last_exec_q, last_exec_d;   // 1: exec owned last, so fetch wins a tie
    logic [2:0]            rvalid_q, rvalid_d;         // {exec, fetch, dma}
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic                  we_d;
    logic                  beat;
    logic                  owner_req;
    logic                  others_pending;
    logic                  limit_hit;
    logic                  rearb;
    logic                  cand_dma, cand_fetch, cand_exec;

    assign gnt_dma   = (state_q == ST_DMA)   & req_dma;
    assign gnt_fetch = (state_q == ST_FETCH) & req_fetch;
    assign gnt_exec  = (state_q == ST_EXEC)  & req_exec;
    assign beat      = gnt_dma | gnt_fetch | gnt_exec;

    assign owner        = state_q;
    assign rdata        = mem_dout;
    assign rvalid_dma   = rvalid_q[0];
    assign rvalid_fetch = rvalid_q[1];
    assign rvalid_exec  = rvalid_q[2];
    assign mem_addr     = addr_d;
    assign mem_din      = din_d;
    assign mem_we       = we_d;

    // Memory port mux: drive the owner's beat, otherwise hold address/data and keep we low.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no latch is inferred.
        addr_d = addr_q;
        din_d  = din_q;
        we_d   = 1'b0;
        if (gnt_dma) begin
            addr_d = addr_dma;
            din_d  = din_dma;
            we_d   = we_dma;
        end else if (gnt_fetch) begin
            addr_d = addr_fetch;
            din_d  = din_fetch;
            we_d   = we_fetch;
        end else if (gnt_exec) begin
            addr_d = addr_exec;
            din_d  = din_exec;
            we_d   = we_exec;
        end
    end

    // Arbitration: decide next owner, burst count and round-robin pointer.
    always_comb begin
        owner_req      = 1'b0;
        others_pending = 1'b0;
        case (state_q)
            ST_DMA: begin
                owner_req      = req_dma;
                others_pending = req_fetch | req_exec;
            end
            ST_FETCH: begin
                owner_req      = req_fetch;
                others_pending = req_dma | req_exec;
            end
            ST_EXEC: begin
                owner_req      = req_exec;
                others_pending = req_dma | req_fetch;
            end
            default: begin
                owner_req      = 1'b0;
                others_pending = 1'b0;
            end
        endcase

        // Count including this cycle's beat, so the switch lands right after the last allowed beat.
        cnt_inc   = (beat && (cnt_q != BURST_MAX)) ? cnt_q + 8'd1 : cnt_q;
        limit_hit = (cnt_inc == BURST_MAX) && others_pending;
        rearb     = (state_q == ST_IDLE) || !owner_req || limit_hit;

        // A burst-limited owner is excluded so the bus really changes hands.
        cand_dma   = req_dma   && !(limit_hit && (state_q == ST_DMA));
        cand_fetch = req_fetch && !(limit_hit && (state_q == ST_FETCH));
        cand_exec  = req_exec  && !(limit_hit && (state_q == ST_EXEC));

        state_d = state_q;
        if (rearb) begin
            if (cand_dma)                    state_d = ST_DMA;
            else if (cand_fetch && cand_exec) state_d = last_exec_q ? ST_FETCH : ST_EXEC;
            else if (cand_fetch)             state_d = ST_FETCH;
            else if (cand_exec)              state_d = ST_EXEC;
            else                             state_d = ST_IDLE;
        end

        // DMA ownership leaves the fetch/exec pointer untouched.
        last_exec_d = last_exec_q;
        if (state_d != state_q) begin
            if (state_d == ST_FETCH) last_exec_d = 1'b0;
            if (state_d == ST_EXEC)  last_exec_d = 1'b1;
        end

        cnt_d = (state_d != state_q) ? 8'd0 : cnt_inc;

        rvalid_d = {gnt_exec & ~we_exec, gnt_fetch & ~we_fetch, gnt_dma & ~we_dma};
    end

    // State, counters, read-valid pipeline and held memory address/data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            last_exec_q <= 1'b1;
            rvalid_q    <= 3'b000;
            addr_q      <= '0;
            din_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_exec_q <= last_exec_d;
            rvalid_q    <= rvalid_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
        end
    end

endmodule
